// File: rtl/xmint_prefetch_buffer.sv
// xmint_prefetch_buffer: in-order instruction prefetch with bounded outstanding requests, redirect and pause
// Ports: clk_i/rst_ni clock and async active-low reset; fetch_enable_i, boot_addr_i, redirect_i and
// redirect_addr_i front-end control; instr_req_o/instr_gnt_i/instr_addr_o request channel;
// instr_rvalid_i/instr_rdata_i/instr_err_i response channel; out_valid_o/out_ready_i/out_rdata_o/
// out_addr_o/out_err_o FIFO head handshake; busy_o request pending or responses outstanding.
module xmint_prefetch_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic [31:0] boot_addr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o,
  output logic        busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {BOOT, RUN, STOP} state_e;
  state_e state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d, resp_addr_q, resp_addr_d, hold_addr_q, hold_addr_d;
  logic hold_q, hold_d, stale_q, stale_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [64:0] mem_q [DEPTH];
  logic boot, flush, can_issue, gnt, rv, push, pop;
  logic unused_low_bits;
  assign unused_low_bits = ^{boot_addr_i[1:0], redirect_addr_i[1:0]};
  assign out_valid_o = cnt_q != '0;
  assign {out_addr_o, out_rdata_o, out_err_o} = mem_q[rd_q];
  always_comb begin
    boot  = state_q == BOOT && fetch_enable_i;
    flush = redirect_i && state_q != BOOT;
    // New requests need a free outstanding slot and a FIFO slot reserved for their response.
    can_issue = state_q == RUN && !hold_q && !flush && out_q < CW'(MAX_OUTSTANDING) &&
                ({1'b0, cnt_q} + {1'b0, out_q}) < (CW+1)'(DEPTH);
    instr_req_o  = hold_q || can_issue;
    instr_addr_o = hold_q ? hold_addr_q : fetch_addr_q;
    busy_o       = instr_req_o || out_q != '0;
    gnt  = instr_req_o && instr_gnt_i;
    rv   = instr_rvalid_i && out_q != '0;
    push = rv && disc_q == '0 && !flush;
    pop  = out_valid_o && out_ready_i && !flush;
    hold_d      = instr_req_o && !instr_gnt_i;
    hold_addr_d = instr_addr_o;
    // A request caught ungranted by a redirect keeps its old address; its response must be dropped.
    stale_d = hold_d && (flush || stale_q);
    state_d = state_q == BOOT ? (fetch_enable_i ? RUN : BOOT) : (fetch_enable_i ? RUN : STOP);
    fetch_addr_d = boot ? {boot_addr_i[31:2], 2'b00} :
                   flush ? {redirect_addr_i[31:2], 2'b00} :
                   (gnt && !stale_q) ? fetch_addr_q + 32'd4 : fetch_addr_q;
    resp_addr_d  = boot ? {boot_addr_i[31:2], 2'b00} :
                   flush ? {redirect_addr_i[31:2], 2'b00} :
                   push ? resp_addr_q + 32'd4 : resp_addr_q;
    out_d = out_q + CW'(gnt) - CW'(rv);
    // After a redirect every response still owed belongs to the old stream.
    disc_d = flush ? out_d : disc_q + CW'(gnt && stale_q) - CW'(rv && disc_q != '0);
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    wr_d  = flush ? '0 : wr_q + AW'(push);
    rd_d  = flush ? '0 : rd_q + AW'(pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= BOOT;
      fetch_addr_q <= '0;
      resp_addr_q  <= '0;
      hold_addr_q  <= '0;
      hold_q       <= 1'b0;
      stale_q      <= 1'b0;
      out_q        <= '0;
      disc_q       <= '0;
      cnt_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      resp_addr_q  <= resp_addr_d;
      hold_addr_q  <= hold_addr_d;
      hold_q       <= hold_d;
      stale_q      <= stale_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= {resp_addr_q, instr_rdata_i, instr_err_i};
  end
endmodule
